// File: rtl/node_address_map_pkg.sv
// Shared defaults and node-id helpers for the node address map.
// Node ids are packed as {x[1:0], y[1:0]}.
package node_address_map_pkg;

    localparam int NODE_BITS_DEF  = 4;
    localparam int LOCAL_BITS_DEF = 10;
    localparam int ADDR_WIDTH_DEF = 32;

    // Extract the x coordinate (upper half) of a node id.
    function automatic logic [1:0] node_x(input logic [3:0] id);
        return id[3:2];
    endfunction

    // Extract the y coordinate (lower half) of a node id.
    function automatic logic [1:0] node_y(input logic [3:0] id);
        return id[1:0];
    endfunction

    // Build a node id from its x and y coordinates.
    function automatic logic [3:0] make_node(input logic [1:0] x, input logic [1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/node_address_calc.sv
// Combinational local-to-global address translation plus window range check.
// The range comparator exists only when ADDR_MAP_BOUNDS_CHECK_EN is defined;
// otherwise out_of_range is tied low.
module node_address_calc
    import node_address_map_pkg::*;
#(
    parameter int NODE_BITS  = NODE_BITS_DEF,
    parameter int LOCAL_BITS = LOCAL_BITS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [NODE_BITS-1:0]  node_id,
    input  logic [ADDR_WIDTH-1:0] local_addr,
    output logic [ADDR_WIDTH-1:0] global_addr,
    output logic                  out_of_range
);

    logic [ADDR_WIDTH-1:0] node_base;

    // Window base is the zero-extended node id shifted into the window field;
    // out-of-window local addresses deliberately spill into the next window.
    always_comb begin
        node_base   = {{(ADDR_WIDTH-NODE_BITS-LOCAL_BITS){1'b0}}, node_id, {LOCAL_BITS{1'b0}}};
        global_addr = node_base + local_addr;
    end

`ifdef ADDR_MAP_BOUNDS_CHECK_EN
    // Any bit above the window offset means the address left the node window.
    always_comb begin
        out_of_range = |local_addr[ADDR_WIDTH-1:LOCAL_BITS];
    end
`else
    assign out_of_range = 1'b0;
`endif

endmodule

// File: rtl/node_address_map.sv
// Node address map: combinational translation of a node-local address into the
// global NoC address space, plus a one-cycle registered copy with valid and
// range-error flags. Optional range check enabled by ADDR_MAP_BOUNDS_CHECK_EN.
module node_address_map
    import node_address_map_pkg::*;
#(
    parameter int NODE_BITS  = NODE_BITS_DEF,
    parameter int LOCAL_BITS = LOCAL_BITS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NODE_BITS-1:0]  NODEADDRESS,
    input  logic [ADDR_WIDTH-1:0] MEMADDRESS,
    input  logic                  REQ,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic                  OUT_OF_RANGE,
    output logic [ADDR_WIDTH-1:0] ADDRESS_Q,
    output logic                  VALID_Q,
    output logic                  ERR_Q
);

    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic                  err_d, err_q;
    logic                  valid_d, valid_q;

    node_address_calc #(
        .NODE_BITS  (NODE_BITS),
        .LOCAL_BITS (LOCAL_BITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_calc (
        .node_id      (NODEADDRESS),
        .local_addr   (MEMADDRESS),
        .global_addr  (ADDRESS),
        .out_of_range (OUT_OF_RANGE)
    );

    // Capture the translation on a request; otherwise hold result, drop valid.
    always_comb begin
        addr_d  = addr_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (REQ) begin
            addr_d  = ADDRESS;
            err_d   = OUT_OF_RANGE;
            valid_d = 1'b1;
        end
    end

    // Output register stage; reset wins over a simultaneous request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign ADDRESS_Q = addr_q;
    assign ERR_Q     = err_q;
    assign VALID_Q   = valid_q;

endmodule

// File: tb/tb_node_address_map.sv
// Testbench for node_address_map: directed boundary cases followed by random
// traffic, with a queue-based scoreboard for the registered outputs.
module tb_node_address_map;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  NODEADDRESS;
    logic [31:0] MEMADDRESS;
    logic        REQ;
    logic [31:0] ADDRESS;
    logic        OUT_OF_RANGE;
    logic [31:0] ADDRESS_Q;
    logic        VALID_Q;
    logic        ERR_Q;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit        v;
        bit [31:0] a;
        bit        e;
    } exp_t;

    exp_t exp_q[$];

    // Reference view of the registered outputs after the most recent edge.
    bit [31:0] ref_addr_q = '0;
    bit        ref_err_q  = 1'b0;

    bit stim_done = 1'b0;

    node_address_map dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .NODEADDRESS  (NODEADDRESS),
        .MEMADDRESS   (MEMADDRESS),
        .REQ          (REQ),
        .ADDRESS      (ADDRESS),
        .OUT_OF_RANGE (OUT_OF_RANGE),
        .ADDRESS_Q    (ADDRESS_Q),
        .VALID_Q      (VALID_Q),
        .ERR_Q        (ERR_Q)
    );

    always #5 CLK = ~CLK;

    function automatic bit [31:0] model_addr(input bit [3:0] node, input bit [31:0] mem);
        bit [63:0] s;
        s = 64'(node) * 64'd1024 + 64'(mem);
        return s[31:0];
    endfunction

    function automatic bit model_oor(input bit [31:0] mem);
`ifdef ADDR_MAP_BOUNDS_CHECK_EN
        return (mem >= 32'd1024);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input bit [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input bit req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus (before the next rising edge), check the
    // combinational outputs, and queue the registered state expected after it.
    task automatic apply(input bit rst, input bit req, input bit [3:0] node, input bit [31:0] mem);
        exp_t x;
        RESET       = rst;
        REQ         = req;
        NODEADDRESS = node;
        MEMADDRESS  = mem;
        #1;
        check32("comb_address", ADDRESS, model_addr(node, mem));
        check1("comb_out_of_range", OUT_OF_RANGE, model_oor(mem));
        if (rst) begin
            ref_addr_q = '0;
            ref_err_q  = 1'b0;
            x.v = 1'b0;
        end else if (req) begin
            ref_addr_q = model_addr(node, mem);
            ref_err_q  = model_oor(mem);
            x.v = 1'b1;
        end else begin
            x.v = 1'b0;
        end
        x.a = ref_addr_q;
        x.e = ref_err_q;
        exp_q.push_back(x);
    endtask

    task automatic step(input bit rst, input bit req, input bit [3:0] node, input bit [31:0] mem);
        @(posedge CLK);
        #1;
        apply(rst, req, node, mem);
    endtask

    // Monitor: after each rising edge, compare registered outputs to the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check1("valid_q", VALID_Q, x.v);
                check32("address_q", ADDRESS_Q, x.a);
                check1("err_q", ERR_Q, x.e);
            end
        end
    end

    // Stimulus.
    initial begin
        bit [31:0] m;
        bit [3:0]  n;
        bit        r, q;
        // First edge: reset together with a request; request must be dropped.
        apply(1'b1, 1'b1, 4'b0101, 32'd10);
        step(1'b0, 1'b0, 4'b0000, 32'd10);
        step(1'b0, 1'b0, 4'b0001, 32'd10);
        step(1'b0, 1'b1, 4'b0101, 32'd10);
        step(1'b0, 1'b0, 4'b0101, 32'd10);
        step(1'b0, 1'b1, 4'b0010, 32'd1023);
        step(1'b0, 1'b1, 4'b0010, 32'd1024);
        step(1'b0, 1'b0, 4'b0000, 32'd0);
        step(1'b0, 1'b1, 4'b1111, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 4'b0011, 32'd77);
        step(1'b0, 1'b0, 4'b0000, 32'd0);
        // Random traffic, including back-to-back requests and occasional resets.
        for (int i = 0; i < 400; i++) begin
            n = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: m = 32'($urandom_range(0, 1023));
                1: m = 32'($urandom_range(1020, 1028));
                2: m = $urandom;
                default: m = 32'hFFFF_FFFF - 32'($urandom_range(0, 2047));
            endcase
            r = ($urandom_range(0, 19) == 0);
            q = ($urandom_range(0, 3) != 0);
            step(r, q, n, m);
        end
        stim_done = 1'b1;
        repeat (2) @(negedge CLK);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion (done=%0d)", stim_done);
        $fatal(1);
    end

endmodule
